// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared decode constants and FSM states for the PCPI M-unit
package muldiv_pkg;
  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;
endpackage

// File: rtl/muldiv_divider.sv
// rtl/muldiv_divider.sv - iterative unsigned restoring divider, DIV_STEP quotient bits per cycle
// quotient/remainder carry the result of the step in flight, so they are final while done=1.
module muldiv_divider #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int N  = XLEN / DIV_STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [XLEN-1:0] quo_q, quo_d, quo_s, dsr_q, dsr_d;
  logic [XLEN:0]   rem_q, rem_d, rem_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            rem_msb_unused;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    quo_s = quo_q;
    rem_s = rem_q;
    for (int i = 0; i < DIV_STEP; i++) begin
      rem_s = {rem_s[XLEN-1:0], quo_s[XLEN-1]};
      quo_s = {quo_s[XLEN-2:0], 1'b0};
      if (rem_s >= {1'b0, dsr_q}) begin
        rem_s    = rem_s - {1'b0, dsr_q};
        quo_s[0] = 1'b1;
      end
    end
  end

  assign done           = busy_q && (cnt_q == LAST);
  assign busy           = busy_q;
  assign quotient       = quo_s;
  assign remainder      = rem_s[XLEN-1:0];
  assign rem_msb_unused = rem_s[XLEN];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      quo_d = quo_s;
      rem_d = rem_s;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end
endmodule

// File: rtl/pcpi_muldiv_seq.sv
// rtl/pcpi_muldiv_seq.sv - PCPI RV32M/RV64M iterative multiply/divide coprocessor
// Define PCPI_MULDIV_FAST_MUL_EN for a single registered multiply instead of shift-add.
module pcpi_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);
  localparam int MUL_N = XLEN / MUL_STEP;
  localparam int CW    = $clog2(MUL_N + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              s1_q, s1_d, s2_q, s2_d, dz_q, dz_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, prod_raw, prod;
  logic [XLEN-1:0]   mplier_q, mplier_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d, wait_q, wait_d;

  logic              match, rs1_sgn, rs2_sgn, mul_last, div_start, div_abort, div_done;
  logic [2:0]        f3_in;
  logic [XLEN-1:0]   abs1, abs2, mul_res, div_quo, div_rem, quo_fix, rem_fix, div_res;
  logic              div_busy_unused, insn_unused;

  assign f3_in   = pcpi_insn[14:12];
  assign match   = pcpi_valid && (pcpi_insn[6:0] == M_OPCODE) && (pcpi_insn[31:25] == M_FUNCT7);
  assign rs1_sgn = pcpi_rs1[XLEN-1] &&
                   (f3_in == F3_MULH || f3_in == F3_MULHSU || f3_in == F3_DIV || f3_in == F3_REM);
  assign rs2_sgn = pcpi_rs2[XLEN-1] && (f3_in == F3_MULH || f3_in == F3_DIV || f3_in == F3_REM);
  assign abs1    = rs1_sgn ? -pcpi_rs1 : pcpi_rs1;
  assign abs2    = rs2_sgn ? -pcpi_rs2 : pcpi_rs2;
  assign insn_unused = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

`ifdef PCPI_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_full;
  logic                     fast_unused;
  assign fast_full   = $signed({1'b0, mcand_q[XLEN-1:0]}) * $signed({1'b0, mplier_q});
  assign prod_raw    = fast_full[2*XLEN-1:0];
  assign fast_unused = ^{fast_full[2*XLEN+1:2*XLEN], acc_q, cnt_q};
  assign mul_last    = 1'b1;
`else
  always_comb begin
    prod_raw = acc_q;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) prod_raw = prod_raw + (mcand_q << i);
    end
  end
  assign mul_last = (cnt_q == MUL_LAST);
`endif

  // Magnitudes are multiplied; the sign is applied once to the full-width product.
  assign prod    = (s1_q ^ s2_q) ? -prod_raw : prod_raw;
  assign mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign div_start = (state_q == ST_IDLE) && match && f3_in[2];
  assign div_abort = (state_q == ST_DIV) && !pcpi_valid;

  muldiv_divider #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (abs1),
    .divisor   (abs2),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Divide by zero keeps the all-ones quotient unsigned; MIN/-1 falls out of the magnitudes.
  assign quo_fix = dz_q ? '1 : ((s1_q ^ s2_q) ? -div_quo : div_quo);
  assign rem_fix = s1_q ? -div_rem : div_rem;
  assign div_res = f3_q[1] ? rem_fix : quo_fix;

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    rd_d     = '0;
    ready_d  = 1'b0;
    wait_d   = wait_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = 1'b0;
        if (match) begin
          f3_d     = f3_in;
          s1_d     = rs1_sgn;
          s2_d     = rs2_sgn;
          dz_d     = (pcpi_rs2 == '0);
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, abs1};
          mplier_d = abs2;
          cnt_d    = '0;
          wait_d   = 1'b1;
          state_d  = f3_in[2] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end else begin
          acc_d    = prod_raw;
          mcand_d  = mcand_q << MUL_STEP;
          mplier_d = mplier_q >> MUL_STEP;
          cnt_d    = cnt_q + 1'b1;
          if (mul_last) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
            rd_d    = mul_res;
          end
        end
      end
      ST_DIV: begin
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
        end else if (div_done) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          rd_d    = div_res;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wait_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      f3_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      ready_q  <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      ready_q  <= ready_d;
      wait_q   <= wait_d;
    end
  end

  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;
  assign pcpi_wait  = wait_q;
endmodule

// File: doc/pcpi_muldiv_seq.md
Name: pcpi_muldiv_seq

Overview:
- Parametrised, iterative RV32M/RV64M multiply/divide coprocessor on the core's PCPI port.
- Replaces the fixed single-width M-unit: operand width, bits retired per cycle for multiply and divide, and abort-on-flush are configurable.
- Sits beside the execute stage. The core holds pcpi_valid while the M-instruction is in execute and stalls until pcpi_ready.

Parameters:
- XLEN, 32: operand/result width; 32 or 64.
- MUL_STEP, 4: multiplier bits consumed per cycle; power of two dividing XLEN.
- DIV_STEP, 1: quotient bits produced per cycle; 1, 2 or 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pcpi_valid  in  1  execute stage holds an M-instruction; held high until pcpi_ready
- pcpi_insn  in  32  instruction word
- pcpi_rs1  in  XLEN  operand A
- pcpi_rs2  in  XLEN  operand B
- pcpi_wr  out  1  result to be written to rd; asserted with pcpi_ready
- pcpi_rd  out  XLEN  result; valid only while pcpi_ready=1
- pcpi_wait  out  1  unit accepted the instruction and is busy
- pcpi_ready  out  1  one-cycle completion pulse

Behaviour:
- Reset
  - Synchronous, active-high; state goes to IDLE.
  - pcpi_wr, pcpi_ready and pcpi_wait are 0; pcpi_rd is 0.
  - Reset mid-operation discards all work, with no ready pulse.
- Decode
  - match = pcpi_valid & opcode==7'b0110011 & funct7==7'b0000001.
  - funct3 selects: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - A non-matching insn is ignored; all outputs stay 0.
- States: IDLE, MUL, DIV, DONE.
  - IDLE & match: latch operands as absolute values plus sign flags, latch funct3 and clear the accumulator. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
  - MUL:
    - Shift-add over 2*XLEN-bit product, MUL_STEP bits per cycle.
    - Runs XLEN/MUL_STEP cycles, then goes to DONE.
    - Signedness: MULH both operands signed; MULHSU rs1 signed, rs2 unsigned; MUL and MULHU unsigned. The final product is negated when the sign flags differ.
  - DIV:
    - Restoring division, DIV_STEP quotient bits per cycle.
    - Runs XLEN/DIV_STEP cycles, then goes to DONE.
    - Signed ops fix up signs at the end: quotient is negative iff the operand signs differ; remainder takes the sign of the dividend.
  - DONE: pcpi_ready=1, pcpi_wr=1 and pcpi_rd driven from a register, all for exactly one cycle. Then go to IDLE.
- Result selection
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
- Latency and handshake
  - Accept cycle is T0; pcpi_wait is registered high from T1 through DONE inclusive.
  - ready at T0+1+XLEN/STEP. Default MUL is 9 cycles, default DIV is 33 cycles.
  - In the cycle after DONE the unit is IDLE and samples pcpi_valid again. A back-to-back M-instruction is therefore accepted then, with no dead cycle. A valid still high in the DONE cycle itself never restarts the unit.
- Divide boundary conditions
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend. Takes the full latency, no early exit.
  - Signed overflow, MIN / -1: quotient = MIN, remainder = 0.
- Abort
  - If pcpi_valid drops in MUL or DIV (pipeline flush), return to IDLE next cycle.
  - No ready pulse, and pcpi_wait goes low.
- Width rule
  - All internal arithmetic is XLEN+1 bits (divider) or 2*XLEN bits (product). No truncation before result selection.

Optional Feature:
- PCPI_MULDIV_FAST_MUL_EN defined:
  - Multiply uses a single registered (XLEN+1)x(XLEN+1) signed multiply.
  - MUL goes to DONE after one cycle; total latency 2 cycles.
  - MUL_STEP is ignored.
- Undefined: iterative shift-add as above.
- Divide is identical in both builds.

Decomposition:
- Package muldiv_pkg:
  - funct3 constants (F3_MUL … F3_REMU).
  - M opcode/funct7 constants.
  - state enumeration (IDLE/MUL/DIV/DONE).
- Sub-module muldiv_divider:
  - Iterative restoring divider with start, busy, done, quotient and remainder; parametrised by XLEN and DIV_STEP.
  - Top level keeps the FSM, sign handling, multiplier and PCPI handshake.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD) -> ready on cycle T0+9, pcpi_rd=0xFFFFFFEB, wr=1. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULH 0x80000000*0x80000000 -> 0x40000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14, REMU -> 2. Each with ready at T0+33.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
- Back-to-back MUL then DIV with valid held continuously -> two ready pulses. The second operation is accepted the cycle after the first ready, with no double accept.
- Abort and reset:
  - valid dropped at T0+5 of a DIV -> no ready; wait=0 by T0+6.
  - reset asserted mid-MUL -> all outputs 0 next cycle; a new MUL afterwards completes correctly.
